param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, >=4.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH-1).
REQ-004 Parameter AEMPTY_LVL, default 2, occupancy at or below which almost_empty asserts (1..DEPTH-1).
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 wr  input  1  write request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 rd  input  1  read request.
REQ-011 data_out  output  WIDTH  read data.
REQ-012 full, empty  output  1 each  storage full / storage empty.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Pointers SHALL be clog2(DEPTH)+1 bits (extra wrap bit); address = low clog2(DEPTH) bits; increment wraps modulo 2*DEPTH.
REQ-017 Write SHALL be accepted iff wr=1 and full=0; accepted write stores data_in at write address and increments write pointer.
REQ-018 Read SHALL be accepted iff rd=1 and empty=0; accepted read increments read pointer.
REQ-019 Acceptance SHALL use pre-edge flag values: when full, wr with rd is rejected, rd accepted; when empty, rd with wr is rejected, wr accepted.
REQ-020 full = wrap bits differ and addresses equal; empty = pointers equal; both combinational from registered pointers.
REQ-021 count SHALL equal (wptr - rptr) modulo 2*DEPTH, combinational from registered pointers.
REQ-022 almost_full = (count >= AFULL_LVL); almost_empty = (count <= AEMPTY_LVL).
REQ-023 FWFT=0: data_out SHALL load the word at read address on the edge of an accepted read (1-cycle latency) and hold otherwise.
REQ-024 FWFT=1: data_out SHALL present the head word whenever empty=0, visible the cycle after the edge writing it into an empty FIFO; accepted read advances to next word in the same cycle; data_out SHALL be 0 when empty=1.
REQ-025 overflow SHALL set on any edge with wr=1 and full=1 and remain set until reset.
REQ-026 underflow SHALL set on any edge with rd=1 and empty=1 and remain set until reset.
REQ-027 Rejected requests SHALL not modify pointers, storage or data_out.
REQ-028 Simultaneous accepted read and write SHALL leave count unchanged.

Reset
REQ-029 rst=1 SHALL immediately clear both pointers, data_out, overflow and underflow, independent of clk.
REQ-030 During reset: empty=1, almost_empty=1, full=0, almost_full=0, count=0; storage contents are don't-care and not cleared.
REQ-031 Reset mid-operation SHALL discard all stored words; first accepted write after release lands at address 0.

Structure
REQ-032 Shared package sync_fifo_pkg SHALL hold default WIDTH/DEPTH constants and the FWFT mode encodings.
REQ-033 Storage SHALL be one sub-module param_fifo_ram (one write port, one read port, synchronous write, combinational read address path); pointer, flag and output logic live in the top.

Verification
REQ-034 DEPTH=16: 16 writes 0x00..0x0F -> full=1, count=16, almost_full from count=14; 17th write -> overflow=1, contents unchanged.
REQ-035 FWFT=0: write 0xA5 then rd next cycle -> data_out=0xA5 one cycle after read edge, empty=1; extra rd -> underflow=1, data_out holds 0xA5.
REQ-036 FWFT=1: single write 0x3C into empty FIFO -> data_out=0x3C next cycle without rd; rd -> empty=1, data_out=0.
REQ-037 Fill to 16, simultaneous wr+rd -> write rejected, read accepted, count=15; at count=8 simultaneous wr+rd for 40 cycles -> count stays 8, pointers wrap, data order preserved.
REQ-038 Empty FIFO, simultaneous wr=1 rd=1 with 0x55 -> count=1, underflow=1, next read returns 0x55.
REQ-039 Write 5 words, assert rst asynchronously mid-cycle -> outputs reach reset values before next edge; after release, write 0x11, read -> 0x11.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants for the parameterised synchronous FIFO family.
//   DefWidth / DefDepth : default data width and storage depth
//   FwftOff / FwftOn    : read-mode encodings for the FWFT parameter
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 16;

    // Read-mode encodings
    localparam int unsigned FwftOff = 0;  // registered read, 1-cycle latency
    localparam int unsigned FwftOn  = 1;  // first-word-fall-through

endpackage

// File: rtl/param_fifo_ram.sv
// ----------------------------------------------------------------------------
// param_fifo_ram
// Simple dual-port storage array for param_sync_fifo.
// One synchronous write port, one combinational read port. Contents are not
// reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module param_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// ----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with wrap-bit pointers, threshold flags, sticky error
// flags and a selectable registered / first-word-fall-through read mode.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   wr, data_in  : write request and data (ignored while full)
//   rd           : read request (ignored while empty)
//   data_out     : read data (registered or FWFT head word)
//   full, empty  : storage occupancy flags
//   almost_full  : count >= AFULL_LVL
//   almost_empty : count <= AEMPTY_LVL
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
// ----------------------------------------------------------------------------
module param_sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned AFULL_LVL  = DEPTH - 2,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter int unsigned FWFT       = FwftOff
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;

    localparam logic [AW:0] PtrOne    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AfullThr  = PtrW'(AFULL_LVL);
    localparam logic [AW:0] AemptyThr = PtrW'(AEMPTY_LVL);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q, udf_q;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] ram_rdata;

    // Flags derive from registered pointers only; acceptance uses pre-edge values.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;

    assign almost_full  = (count >= AfullThr);
    assign almost_empty = (count <= AemptyThr);

    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    param_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + PtrOne;
                dout_q <= ram_rdata;
            end
            if (wr && full) begin
                ovf_q <= 1'b1;
            end
            if (rd && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    // FWFT shows the head word straight off the array; forced to zero when empty
    // so stale storage never leaks out.
    always_comb begin
        data_out = dout_q;
        if (FWFT == FwftOn) begin
            data_out = empty ? '0 : ram_rdata;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_sync_fifo
// Two FIFOs (registered-read and FWFT) share one stimulus stream; flags are
// checked on both, data_out on each against its own expectation.
// ----------------------------------------------------------------------------
module tb_param_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] count0, count1;

    int n_tests = 0;
    int n_fail  = 0;

    param_sync_fifo #(
        .WIDTH (8),
        .DEPTH (16),
        .FWFT  (0)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (dout0),
        .full         (full0),
        .empty        (empty0),
        .almost_full  (af0),
        .almost_empty (ae0),
        .count        (count0),
        .overflow     (ovf0),
        .underflow    (udf0)
    );

    param_sync_fifo #(
        .WIDTH (8),
        .DEPTH (16),
        .FWFT  (1)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (dout1),
        .full         (full1),
        .empty        (empty1),
        .almost_full  (af1),
        .almost_empty (ae1),
        .count        (count1),
        .overflow     (ovf1),
        .underflow    (udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] din,
                                input int cnt, input logic fl, input logic em,
                                input logic af, input logic ae, input logic ovf,
                                input logic udf, input logic [7:0] d0,
                                input logic [7:0] d1);
        vec_t v;
        v.wr = w;   v.rd = r;     v.din = din;  v.cnt = 5'(cnt);
        v.full = fl; v.empty = em; v.af = af;   v.ae = ae;
        v.ovf = ovf; v.udf = udf;  v.d0 = d0;   v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic w, input logic r, input logic [7:0] din);
        wr = w;
        rd = r;
        data_in = din;
        step();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic fl,
                               input logic em, input logic af, input logic ae,
                               input logic ovf, input logic udf);
        check({tag, " count"}, 32'(count0), 32'(cnt));
        check({tag, " full"}, 32'(full0), 32'(fl));
        check({tag, " empty"}, 32'(empty0), 32'(em));
        check({tag, " almost_full"}, 32'(af0), 32'(af));
        check({tag, " almost_empty"}, 32'(ae0), 32'(ae));
        check({tag, " overflow"}, 32'(ovf0), 32'(ovf));
        check({tag, " underflow"}, 32'(udf0), 32'(udf));
        check({tag, " fwft count"}, 32'(count1), 32'(cnt));
        check({tag, " fwft empty"}, 32'(empty1), 32'(em));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;

        rst = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        data_in = 8'h00;
        #2;
        check_flags("reset", 0, 0, 1, 0, 1, 0, 0);
        check("reset dout0", 32'(dout0), 32'h0);
        check("reset dout1", 32'(dout1), 32'h0);
        step();
        rst = 1'b0;

        // Single word through both read modes, then underflow
        apply(1, 0, 8'hA5);
        check_flags("wrA5", 1, 0, 0, 0, 1, 0, 0);
        check("wrA5 dout0 holds", 32'(dout0), 32'h0);
        check("wrA5 fwft head", 32'(dout1), 32'hA5);
        apply(0, 1, 8'h00);
        check_flags("rdA5", 0, 0, 1, 0, 1, 0, 0);
        check("rdA5 dout0", 32'(dout0), 32'hA5);
        check("rdA5 fwft empty zero", 32'(dout1), 32'h0);
        apply(0, 1, 8'h00);
        check_flags("rd empty", 0, 0, 1, 0, 1, 0, 1);
        check("rd empty dout0 holds", 32'(dout0), 32'hA5);

        do_reset();
        check("post-reset underflow", 32'(udf0), 32'h0);
        apply(1, 0, 8'h3C);
        check("wr3C fwft head", 32'(dout1), 32'h3C);
        apply(0, 0, 8'h00);
        check("idle fwft head", 32'(dout1), 32'h3C);
        apply(0, 1, 8'h00);
        check("rd3C fwft empty", 32'(dout1), 32'h0);
        check("rd3C empty", 32'(empty1), 32'h1);
        check("rd3C dout0", 32'(dout0), 32'h3C);

        // Fill, overflow, full-with-read, partial drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tbl[i] = mk(1, 0, 8'(i), i + 1, i == 15, 0, (i + 1) >= 14, (i + 1) <= 2,
                        0, 0, 8'h00, 8'h00);
        end
        tbl[16] = mk(1, 0, 8'hEE, 16, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00);
        tbl[17] = mk(1, 1, 8'hDD, 15, 0, 0, 1, 0, 1, 0, 8'h00, 8'h01);
        for (int k = 18; k < 25; k++) begin
            tbl[k] = mk(0, 1, 8'h00, 32 - k, 0, 0, (32 - k) >= 14, 0, 1, 0,
                        8'(k - 17), 8'(k - 16));
        end
        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check_flags($sformatf("vec%0d", i), int'(tbl[i].cnt), tbl[i].full,
                        tbl[i].empty, tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].udf);
            check($sformatf("vec%0d dout0", i), 32'(dout0), 32'(tbl[i].d0));
            check($sformatf("vec%0d dout1", i), 32'(dout1), 32'(tbl[i].d1));
        end

        // Steady state at count 8 long enough for both pointers to wrap
        for (int v = 8; v < 16; v++) q.push_back(8'(v));
        for (int k = 0; k < 40; k++) begin
            exp_d = q.pop_front();
            q.push_back(8'(8'h80 + k));
            apply(1, 1, 8'(8'h80 + k));
            check($sformatf("wrap%0d count", k), 32'(count0), 32'd8);
            check($sformatf("wrap%0d dout0", k), 32'(dout0), 32'(exp_d));
            check($sformatf("wrap%0d dout1", k), 32'(dout1), 32'(q[0]));
        end
        for (int k = 0; k < 8; k++) begin
            exp_d = q.pop_front();
            apply(0, 1, 8'h00);
            check($sformatf("drain%0d dout0", k), 32'(dout0), 32'(exp_d));
        end
        check("drained empty", 32'(empty0), 32'h1);

        // Simultaneous wr+rd on empty: write accepted, read rejected
        do_reset();
        apply(1, 1, 8'h55);
        check_flags("wr+rd empty", 1, 0, 0, 0, 1, 0, 1);
        check("wr+rd empty dout0", 32'(dout0), 32'h0);
        check("wr+rd empty dout1", 32'(dout1), 32'h55);
        apply(0, 1, 8'h00);
        check("read 55", 32'(dout0), 32'h55);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) apply(1, 0, 8'(8'h21 + i));
        apply(0, 1, 8'h00);
        check("pre-rst dout0", 32'(dout0), 32'h21);
        check("pre-rst count", 32'(count0), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check_flags("async rst", 0, 0, 1, 0, 1, 0, 0);
        check("async rst dout0", 32'(dout0), 32'h0);
        check("async rst dout1", 32'(dout1), 32'h0);
        step();
        rst = 1'b0;
        apply(1, 0, 8'h11);
        check("post-rst fwft head", 32'(dout1), 32'h11);
        apply(0, 1, 8'h00);
        check("post-rst read", 32'(dout0), 32'h11);
        check("post-rst empty", 32'(empty0), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
